// File: rtl/tx_gate_pkg.sv
// Shared constants for the tx_gate transmission-gate model.
package tx_gate_pkg;

   localparam int unsigned HOLD_Z    = 0;
   localparam int unsigned HOLD_LAST = 1;
   localparam int unsigned CNT_W_DEF = 16;

endpackage : tx_gate_pkg

// File: rtl/tx_gate_edge_det.sv
// Registered rise/fall pulse detector for a single-bit control, sampled on clk.
module tx_gate_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_d_q;
   logic r_rise;
   logic r_fall;

   // Previous sample starts at 0 so the first conducting cycle after reset reports a rise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_d_q  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_d_q  <= i_d;
         r_rise <= i_d & ~r_d_q;
         r_fall <= ~i_d & r_d_q;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule : tx_gate_edge_det

// File: rtl/tx_gate.sv
// Transmission gate: combinational pass path plus clocked tracking of gate state.
module tx_gate
   import tx_gate_pkg::*;
#(
   parameter int unsigned WIDTH     = 1,
   parameter int unsigned HOLD_LAST = 0,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_sel,
   input  logic [WIDTH-1:0]  i_in,
   output wire  [WIDTH-1:0]  o_out,
   output logic              o_gate_on,
   output logic [WIDTH-1:0]  o_last_val,
   output logic              o_sel_rise,
   output logic              o_sel_fall,
   output logic [CNT_W-1:0]  o_on_cycles
);

   logic             w_gate_on;
   logic [WIDTH-1:0] r_last_val;
   logic [CNT_W-1:0] r_on_cycles;

   // Reset overrides sel immediately so the bus is released in the reset cycle.
   assign w_gate_on = i_sel & ~i_rst;
   assign o_gate_on = w_gate_on;

   generate
      if (HOLD_LAST == tx_gate_pkg::HOLD_LAST) begin : g_hold
         assign o_out = w_gate_on ? i_in : r_last_val;
      end else begin : g_hiz
         assign o_out = w_gate_on ? i_in : {WIDTH{1'bz}};
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_val <= '0;
      end else if (w_gate_on) begin
         r_last_val <= i_in;
      end
   end

   // Saturating on-time counter; holds at all-ones instead of wrapping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_on_cycles <= '0;
      end else if (w_gate_on && (r_on_cycles != {CNT_W{1'b1}})) begin
         r_on_cycles <= r_on_cycles + CNT_W'(1);
      end
   end

   tx_gate_edge_det u_edge_det (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_d    (i_sel),
      .o_rise (o_sel_rise),
      .o_fall (o_sel_fall)
   );

   assign o_last_val  = r_last_val;
   assign o_on_cycles = r_on_cycles;

endmodule : tx_gate

// File: tb/tb_tx_gate.sv
// Bench for tx_gate: three configurations driven together and checked against a cycle model.
module tb_tx_gate;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic [0:0] in_z;
   logic [7:0] in_h;
   logic [3:0] in_s;

   wire  [0:0]  out_z;
   logic        gate_z, rise_z, fall_z;
   logic [0:0]  last_z;
   logic [15:0] cnt_z;

   wire  [7:0]  out_h;
   logic        gate_h, rise_h, fall_h;
   logic [7:0]  last_h;
   logic [15:0] cnt_h;

   wire  [3:0]  out_s;
   logic        gate_s, rise_s, fall_s;
   logic [3:0]  last_s;
   logic [2:0]  cnt_s;

   // Released outputs float up, so high-Z reads back as all-ones.
   pullup (out_z[0]);
   for (genvar b = 0; b < 4; b++) begin : g_pu
      pullup (out_s[b]);
   end

   always #20 clk = ~clk;

   tx_gate #(.WIDTH(1), .HOLD_LAST(0), .CNT_W(16)) u_z (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_in(in_z), .o_out(out_z),
      .o_gate_on(gate_z), .o_last_val(last_z), .o_sel_rise(rise_z),
      .o_sel_fall(fall_z), .o_on_cycles(cnt_z));

   tx_gate #(.WIDTH(8), .HOLD_LAST(1), .CNT_W(16)) u_h (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_in(in_h), .o_out(out_h),
      .o_gate_on(gate_h), .o_last_val(last_h), .o_sel_rise(rise_h),
      .o_sel_fall(fall_h), .o_on_cycles(cnt_h));

   tx_gate #(.WIDTH(4), .HOLD_LAST(0), .CNT_W(3)) u_s (
      .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_in(in_s), .o_out(out_s),
      .o_gate_on(gate_s), .o_last_val(last_s), .o_sel_rise(rise_s),
      .o_sel_fall(fall_s), .o_on_cycles(cnt_s));

   int         n_cmp = 0;
   int         n_bad = 0;
   int         m_cnt  [3];
   logic [7:0] m_last [3];
   logic       m_prev, m_rise, m_fall;

   function automatic int cmax(input int i);
      return (i == 2) ? 7 : 65535;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour at one rising edge, from the inputs held across it.
   task automatic model_edge();
      logic [7:0] din [3];
      din[0] = {7'b0, in_z};
      din[1] = in_h;
      din[2] = {4'b0, in_s};
      if (rst) begin
         m_prev = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_last[i] = 8'h00;
         end
      end else begin
         m_rise = sel && !m_prev;
         m_fall = !sel && m_prev;
         m_prev = sel;
         if (sel) begin
            for (int i = 0; i < 3; i++) begin
               m_last[i] = din[i];
               if (m_cnt[i] < cmax(i)) m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
   endtask

   task automatic check_regs();
      chk("rise_z", 32'(rise_z), 32'(m_rise));
      chk("fall_z", 32'(fall_z), 32'(m_fall));
      chk("rise_h", 32'(rise_h), 32'(m_rise));
      chk("fall_h", 32'(fall_h), 32'(m_fall));
      chk("rise_s", 32'(rise_s), 32'(m_rise));
      chk("fall_s", 32'(fall_s), 32'(m_fall));
      chk("last_z", 32'(last_z), 32'(m_last[0]));
      chk("last_h", 32'(last_h), 32'(m_last[1]));
      chk("last_s", 32'(last_s), 32'(m_last[2]));
      chk("cnt_z",  32'(cnt_z),  32'(m_cnt[0]));
      chk("cnt_h",  32'(cnt_h),  32'(m_cnt[1]));
      chk("cnt_s",  32'(cnt_s),  32'(m_cnt[2]));
   endtask

   task automatic check_comb();
      logic g;
      g = sel && !rst;
      chk("gate_z", 32'(gate_z), 32'(g));
      chk("gate_h", 32'(gate_h), 32'(g));
      chk("gate_s", 32'(gate_s), 32'(g));
      chk("out_z", 32'(out_z), g ? 32'(in_z) : 32'h1);
      chk("out_h", 32'(out_h), g ? 32'(in_h) : 32'(m_last[1]));
      chk("out_s", 32'(out_s), g ? 32'(in_s) : 32'hF);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_regs();
   endtask

   task automatic rand_in();
      in_z = 1'($urandom);
      in_h = 8'($urandom);
      in_s = 4'($urandom);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0; m_last[i] = 8'h00;
      end
      m_prev = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      rst = 1'b1; sel = 1'b0; in_z = 1'b0; in_h = 8'h00; in_s = 4'h0;

      // Reset state
      tick(); tick();
      check_comb();

      // Gate off: outputs released while in toggles
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_z = 1'b1; in_s = 4'h5; #1 check_comb();
         in_z = 1'b0; in_s = 4'h0; #1 check_comb();
         tick();
      end
      chk("off_cnt_z", 32'(cnt_z), 32'd0);

      // Conducting: out follows in within the same step; five edges counted
      sel = 1'b1;
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 3; j++) begin
            rand_in();
            #1 check_comb();
            if (j < 2) #9;
         end
         tick();
      end
      chk("five_cnt_z", 32'(cnt_z), 32'd5);

      // Hold mode keeps the last passed value after the gate opens
      in_h = 8'hA5;
      tick();
      sel = 1'b0;
      #1 chk("hold_a5", 32'(out_h), 32'hA5);
      in_h = 8'h3C;
      #1 chk("hold_3c", 32'(out_h), 32'hA5);
      check_comb();
      tick();
      chk("fall_pulse", 32'(fall_z), 32'd1);
      tick();
      chk("fall_clear", 32'(fall_z), 32'd0);

      // Reset while conducting releases immediately and clears next edge
      sel = 1'b1; in_z = 1'b1; in_h = 8'h5A; in_s = 4'h9;
      tick(); tick();
      rst = 1'b1; in_z = 1'b0; in_h = 8'hC3;
      #1 check_comb();
      chk("rst_out_h", 32'(out_h), 32'h5A);
      tick();
      chk("rst_cnt_z", 32'(cnt_z), 32'd0);
      check_comb();
      rst = 1'b0;

      // Saturation of the narrow counter
      for (int k = 0; k < 10; k++) begin
         rand_in();
         #1 check_comb();
         tick();
      end
      chk("sat_s", 32'(cnt_s), 32'd7);
      chk("nosat_z", 32'(cnt_z), 32'd10);

      // Random traffic with occasional resets
      for (int k = 0; k < 80; k++) begin
         sel = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 15) == 0);
         rand_in();
         #1 check_comb();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_tx_gate
